// File: rtl/perf_pkg.sv
// Package: perf_pkg
// Shared definitions for the performance counter block: FSM state encoding,
// default counter width and the default opcode that halts counting.
// Configuration macro used by the block: PERF_INSTR_COUNT_EN (see perf_counter).
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } perf_state_e;

    localparam int unsigned PERF_CNT_W   = 16;
    localparam logic [3:0]  PERF_STOP_OP = 4'b0001;

endpackage

// File: rtl/sat_counter.sv
// Module: sat_counter
// Saturating up-counter with synchronous clear. Sticks at all-ones, never wraps.
// Ports:
//   clock  in  1  counter clock
//   reset  in  1  asynchronous, active-high reset (q -> 0)
//   clr    in  1  synchronous clear, wins over inc
//   inc    in  1  increment enable
//   q      out W  current count (registered)
module sat_counter
    import perf_pkg::*;
#(
    parameter int unsigned W = PERF_CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MaxVal = {W{1'b1}};

    logic [W-1:0] r_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != MaxVal)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/perf_counter.sv
// Module: perf_counter
// Cycle counter for the multicycle processor. Starts on the first instruction
// fetch (ir_load) after reset/clear, counts every cycle while running, and
// freezes once a freshly loaded STOP opcode is seen in the IR.
// Configuration: define PERF_INSTR_COUNT_EN to add the instr_count output,
// a saturating count of instruction fetches (including the STOP fetch).
// Ports:
//   clock        in   1      processor clock
//   reset        in   1      asynchronous, active-high reset
//   clear        in   1      synchronous restart to IDLE with zeroed counters
//   ir_load      in   1      IR load strobe; IR takes a new opcode at this edge
//   instr        in   OP_W   opcode currently held in the IR
//   cycle_count  out  CNT_W  counted cycles (saturating)
//   instr_count  out  CNT_W  counted fetches (only with PERF_INSTR_COUNT_EN)
//   running      out  1      high while in RUN
//   halted       out  1      high while in HALT
module perf_counter
    import perf_pkg::*;
#(
    parameter int unsigned    CNT_W   = PERF_CNT_W,
    parameter int unsigned    OP_W    = 4,
    parameter logic [OP_W-1:0] STOP_OP = OP_W'(PERF_STOP_OP)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             ir_load,
    input  logic [OP_W-1:0]  instr,
    output logic [CNT_W-1:0] cycle_count,
`ifdef PERF_INSTR_COUNT_EN
    output logic [CNT_W-1:0] instr_count,
`endif
    output logic             running,
    output logic             halted
);

    perf_state_e r_state;
    perf_state_e w_state_next;
    logic        r_ir_loaded_d;
    logic        w_stop_det;
    logic        w_cyc_inc;

    // instr only holds a new opcode the cycle after a load; a stale STOP left
    // in the IR must not halt the counter.
    assign w_stop_det = r_ir_loaded_d && (instr == STOP_OP);

    always_comb begin
        w_state_next = r_state;
        w_cyc_inc    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (ir_load) begin
                    // The fetch cycle itself is counted: 0 -> 1 on this edge.
                    w_state_next = RUN;
                    w_cyc_inc    = 1'b1;
                end
            end
            RUN: begin
                // The STOP-detect cycle is still counted.
                w_cyc_inc = 1'b1;
                if (w_stop_det) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (clear) begin
            w_state_next = IDLE;
            w_cyc_inc    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ir_loaded_d <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ir_loaded_d <= clear ? 1'b0 : ir_load;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (clear),
        .inc   (w_cyc_inc),
        .q     (cycle_count)
    );

`ifdef PERF_INSTR_COUNT_EN
    logic w_ins_inc;

    assign w_ins_inc = !clear && ir_load && ((r_state == IDLE) || (r_state == RUN));

    sat_counter #(
        .W (CNT_W)
    ) u_instr_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (clear),
        .inc   (w_ins_inc),
        .q     (instr_count)
    );
`endif

    assign running = (r_state == RUN);
    assign halted  = (r_state == HALT);

endmodule
